serial_addsub32: RTL and testbench
==================================

Name: serial_addsub32

Overview:
Multi-cycle 32-bit add/subtract unit: the consuming end of the ALU's conditional-invert path.
- Operand B is XORed with the sub control bit internally; the sub control bit also seeds the carry-in, forming the two's complement.
- The sum is resolved LSB-first, STEP bits per clock, through a narrow ripple slice.
- Sits beside the combinational ALU as a low-area arithmetic path under start/done handshake control.

Parameters:
WIDTH, 32, operand/result width in bits.
STEP, 1, bits resolved per cycle; must divide WIDTH (legal values 1, 2, 4, 8).

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  request; sampled only when ready=1.
sub  input  1  0 = A+B, 1 = A-B; sampled with start.
a  input  WIDTH  operand A; sampled with start.
b  input  WIDTH  operand B; sampled with start.
ready  output  1  high in IDLE and DONE; start is accepted only here.
busy  output  1  high in RUN.
done  output  1  high in DONE; result outputs are valid while high.
result  output  WIDTH  sum or difference.
cout  output  1  final carry out (subtract: 1 = no borrow).
ovf  output  1  signed overflow.
zero  output  1  result == 0.

Behaviour:
- Reset (async assert, rst_n=0):
  - state goes to IDLE.
  - result=0, cout=0, ovf=0, zero=0, done=0, busy=0, ready=1.
  - Operand/carry/count registers are cleared.
  - Deassertion is sampled synchronously (next rising edge).
- States and transitions:
  - IDLE -> RUN on start=1.
  - RUN -> DONE when count reaches WIDTH/STEP-1 and that slice completes.
  - DONE -> RUN on start=1; otherwise DONE holds.
  - No other transitions.
- Accept (start=1 while ready=1):
  - Latch opa=a and opb=b XOR {WIDTH{sub}}.
  - carry=sub, count=0, result shift register cleared.
  - done drops in the same edge.
- RUN, each cycle:
  - Slice adds opa[STEP-1:0] + opb[STEP-1:0] + carry.
  - Sum bits shift into result from the MSB end; opa and opb shift right by STEP.
  - carry updates and count increments.
  - On the last slice, record carry-into-MSB (c_msb) and the final carry.
- Latency: WIDTH/STEP cycles from the accepting edge to done=1. Default is 32 cycles: start sampled at edge 0, done high after edge 32.
- Flags (registered on entry to DONE, held stable until the next accept or reset):
  - cout = final carry.
  - ovf = c_msb XOR final carry.
  - zero = (result == 0).
- start while busy: ignored; no restart, no queueing.
- Back-to-back: start high in DONE restarts immediately. done is low for exactly WIDTH/STEP cycles, then high again.
- a, b, sub may change freely during RUN; only the values sampled at accept matter.
- Reset mid-RUN: abort immediately, all outputs return to reset values, and no partial result is exposed.
- Invariant: exactly one of ready/busy is high; done implies ready.
- Arithmetic is modulo 2^WIDTH; no saturation.

Decomposition:
- Shared package holds:
  - ADDSUB_WIDTH=32 and the legal STEP values.
  - State enum: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - Flag bundle typedef {cout, ovf, zero}, reusable by the combinational ALU.
- One sub-module: addsub_slice. It is a STEP-bit ripple full-adder chain with inputs x, y, cin and outputs s, cout, c_msb (carry into its top bit).
- The top level owns the FSM, counter, shift registers and operand inversion.

Test Plan:
1. a=5, b=3, sub=0 -> after 32 cycles: done=1, result=0x00000008, cout=0, ovf=0, zero=0; busy high for exactly 32 cycles.
2. a=5, b=3, sub=1 -> result=0x00000002, cout=1, ovf=0. Then a=3, b=5, sub=1 -> result=0xFFFFFFFE, cout=0, ovf=0.
3. a=0x7FFFFFFF, b=1, sub=0 -> result=0x80000000, ovf=1, cout=0. Then a=0x80000000, b=1, sub=1 -> result=0x7FFFFFFF, ovf=1, cout=1.
4. a=0xDEADBEEF, b=0xDEADBEEF, sub=1 -> result=0, zero=1, cout=1, ovf=0. Repeat with STEP=4: identical result, done after 8 cycles.
5. Pulse start with new operands at cycle 10 of RUN -> ignored; original result delivered at cycle 32. Then hold start in DONE -> done low 32 cycles, second result correct.
6. Assert rst_n=0 asynchronously at cycle 15 of RUN -> outputs at reset values before the next edge. Release, issue a=1, b=1, sub=0 -> result=2 after 32 cycles.

Source files
------------

// File: rtl/serial_addsub32_pkg.sv
// Shared types for the serial add/subtract path.
// Also intended for reuse by the combinational ALU flag logic.
package serial_addsub32_pkg;

    localparam int ADDSUB_WIDTH = 32;

    localparam int ADDSUB_STEP_1 = 1;
    localparam int ADDSUB_STEP_2 = 2;
    localparam int ADDSUB_STEP_4 = 4;
    localparam int ADDSUB_STEP_8 = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } addsub_state_e;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
    } addsub_flags_t;

    function automatic bit addsub_step_legal(input int step);
        return (step == ADDSUB_STEP_1) || (step == ADDSUB_STEP_2) ||
               (step == ADDSUB_STEP_4) || (step == ADDSUB_STEP_8);
    endfunction

endpackage

// File: rtl/serial_addsub32_slice.sv
// Narrow ripple-carry slice resolving STEP sum bits.
// c_msb is the carry into the top bit, used for signed overflow.
module addsub_slice #(
    parameter int STEP = 1
) (
    input  logic [STEP-1:0] x,
    input  logic [STEP-1:0] y,
    input  logic            cin,
    output logic [STEP-1:0] s,
    output logic            cout,
    output logic            c_msb
);

    logic c;

    // Ripple the carry through STEP full adders.
    always_comb begin
        c     = cin;
        c_msb = cin;
        s     = '0;
        for (int i = 0; i < STEP; i++) begin
            c_msb = c;
            s[i]  = x[i] ^ y[i] ^ c;
            c     = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/serial_addsub32.sv
// Multi-cycle add/subtract: operands latched on start, sum
// resolved LSB-first STEP bits per clock, flags held in DONE.
module serial_addsub32
    import serial_addsub32_pkg::*;
#(
    parameter int WIDTH = ADDSUB_WIDTH,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NSLICE = WIDTH / STEP;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    addsub_state_e state_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    addsub_flags_t    flags_q;

    logic [STEP-1:0]  sl_s;
    logic             sl_cout;
    logic             sl_cmsb;

    addsub_slice #(
        .STEP (STEP)
    ) u_slice (
        .x     (opa_q[STEP-1:0]),
        .y     (opb_q[STEP-1:0]),
        .cin   (carry_q),
        .s     (sl_s),
        .cout  (sl_cout),
        .c_msb (sl_cmsb)
    );

    // Next result value with this cycle's slice shifted in at the MSB end.
    always_comb begin
        res_d = {sl_s, res_q[WIDTH-1:STEP]};
    end

    // Control FSM plus operand/result shift registers and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            flags_q <= '0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q <= RUN;
                        opa_q   <= a;
                        opb_q   <= b ^ {WIDTH{sub}};
                        carry_q <= sub;
                        cnt_q   <= '0;
                        res_q   <= '0;
                        flags_q <= '0;
                    end
                end
                RUN: begin
                    opa_q   <= opa_q >> STEP;
                    opb_q   <= opb_q >> STEP;
                    res_q   <= res_d;
                    carry_q <= sl_cout;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_q      <= DONE;
                        flags_q.cout <= sl_cout;
                        flags_q.ovf  <= sl_cmsb ^ sl_cout;
                        flags_q.zero <= (res_d == '0);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready  = (state_q == IDLE) || (state_q == DONE);
    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign result = res_q;
    assign cout   = flags_q.cout;
    assign ovf    = flags_q.ovf;
    assign zero   = flags_q.zero;

endmodule

// File: tb/tb_serial_addsub32.sv
// Directed bench for serial_addsub32 (STEP=1 and STEP=4 instances).
// Expected values are hand-computed constants.
module tb_serial_addsub32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        ready, busy, done, cout, ovf, zero;
    logic [31:0] result;

    logic        start4 = 1'b0;
    logic        sub4 = 1'b0;
    logic [31:0] a4 = '0;
    logic [31:0] b4 = '0;
    logic        ready4, busy4, done4, cout4, ovf4, zero4;
    logic [31:0] result4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_addsub32 #(.WIDTH(32), .STEP(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub),
        .a(a), .b(b), .ready(ready), .busy(busy), .done(done),
        .result(result), .cout(cout), .ovf(ovf), .zero(zero)
    );

    serial_addsub32 #(.WIDTH(32), .STEP(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4),
        .a(a4), .b(b4), .ready(ready4), .busy(busy4), .done(done4),
        .result(result4), .cout(cout4), .ovf(ovf4), .zero(zero4)
    );

    // Handshake invariant: exactly one of ready/busy, done implies ready.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checks++;
            if ((ready ^ busy) !== 1'b1 || (done === 1'b1 && ready !== 1'b1)) begin
                failures++;
                $display("FAIL invariant ready=%b busy=%b done=%b", ready, busy, done);
            end
        end
    end

    task automatic issue(input logic [31:0] ta, input logic [31:0] tb_, input logic ts);
        @(negedge clk);
        a = ta; b = tb_; sub = ts; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = ~ta; b = ~tb_; sub = ~ts;
    endtask

    task automatic wait_done(input int n0, output int lat, output int bcnt);
        lat = n0;
        bcnt = (busy === 1'b1) ? 1 : 0;
        while (done !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
            if (busy === 1'b1) bcnt++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({ready, busy, done, cout, ovf, zero} !== 6'b100000 || result !== 32'h0) begin
            failures++;
            $display("FAIL reset_state got r=%b b=%b d=%b c=%b o=%b z=%b res=%h exp 100000/0",
                     ready, busy, done, cout, ovf, zero, result);
        end
        checks++;
        if ({ready4, busy4, done4, cout4, ovf4, zero4} !== 6'b100000 || result4 !== 32'h0) begin
            failures++;
            $display("FAIL reset_state4 got r=%b b=%b d=%b res=%h exp 100/0",
                     ready4, busy4, done4, result4);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        int lat, bc;
        issue(32'd5, 32'd3, 1'b0);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL add_accept got busy=%b done=%b exp 1/0", busy, done);
        end
        wait_done(0, lat, bc);
        checks++;
        if (lat !== 32) begin
            failures++;
            $display("FAIL add_latency got=%0d exp=32", lat);
        end
        checks++;
        if (bc !== 32) begin
            failures++;
            $display("FAIL add_busy_cycles got=%0d exp=32", bc);
        end
        checks++;
        if (result !== 32'h00000008 || {cout, ovf, zero} !== 3'b000) begin
            failures++;
            $display("FAIL add_5_3 got=%h c/o/z=%b exp=00000008 000", result, {cout, ovf, zero});
        end
    endtask

    task automatic test_sub();
        int lat, bc;
        issue(32'd5, 32'd3, 1'b1);
        wait_done(0, lat, bc);
        checks++;
        if (result !== 32'h00000002 || {cout, ovf, zero} !== 3'b100) begin
            failures++;
            $display("FAIL sub_5_3 got=%h c/o/z=%b exp=00000002 100", result, {cout, ovf, zero});
        end
        issue(32'd3, 32'd5, 1'b1);
        wait_done(0, lat, bc);
        checks++;
        if (result !== 32'hFFFFFFFE || {cout, ovf, zero} !== 3'b000) begin
            failures++;
            $display("FAIL sub_3_5 got=%h c/o/z=%b exp=FFFFFFFE 000", result, {cout, ovf, zero});
        end
    endtask

    task automatic test_overflow();
        int lat, bc;
        issue(32'h7FFFFFFF, 32'd1, 1'b0);
        wait_done(0, lat, bc);
        checks++;
        if (result !== 32'h80000000 || {cout, ovf, zero} !== 3'b010) begin
            failures++;
            $display("FAIL ovf_add got=%h c/o/z=%b exp=80000000 010", result, {cout, ovf, zero});
        end
        issue(32'h80000000, 32'd1, 1'b1);
        wait_done(0, lat, bc);
        checks++;
        if (result !== 32'h7FFFFFFF || {cout, ovf, zero} !== 3'b110) begin
            failures++;
            $display("FAIL ovf_sub got=%h c/o/z=%b exp=7FFFFFFF 110", result, {cout, ovf, zero});
        end
    endtask

    task automatic test_zero();
        int lat, bc;
        issue(32'hDEADBEEF, 32'hDEADBEEF, 1'b1);
        wait_done(0, lat, bc);
        checks++;
        if (result !== 32'h0 || {cout, ovf, zero} !== 3'b101) begin
            failures++;
            $display("FAIL zero_sub got=%h c/o/z=%b exp=00000000 101", result, {cout, ovf, zero});
        end
    endtask

    task automatic test_step4();
        int n;
        @(negedge clk);
        a4 = 32'hDEADBEEF; b4 = 32'hDEADBEEF; sub4 = 1'b1; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0; a4 = 32'h12345678; sub4 = 1'b0;
        n = 0;
        while (done4 !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 8) begin
            failures++;
            $display("FAIL step4_latency got=%0d exp=8", n);
        end
        checks++;
        if (result4 !== 32'h0 || {cout4, ovf4, zero4} !== 3'b101) begin
            failures++;
            $display("FAIL step4_zero got=%h c/o/z=%b exp=00000000 101",
                     result4, {cout4, ovf4, zero4});
        end
    endtask

    task automatic test_ignore_start();
        int lat, bc;
        issue(32'd100, 32'd23, 1'b0);
        repeat (10) @(negedge clk);
        a = 32'd1; b = 32'd1; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(11, lat, bc);
        checks++;
        if (lat !== 32) begin
            failures++;
            $display("FAIL ignore_latency got=%0d exp=32", lat);
        end
        checks++;
        if (result !== 32'h0000007B || {cout, ovf, zero} !== 3'b000) begin
            failures++;
            $display("FAIL ignore_result got=%h c/o/z=%b exp=0000007B 000",
                     result, {cout, ovf, zero});
        end
    endtask

    task automatic test_back_to_back();
        int n, low;
        a = 32'd7; b = 32'd9; sub = 1'b0; start = 1'b1;
        n = 0;
        low = 0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) break;
            low++;
        end
        start = 1'b0;
        checks++;
        if (low !== 32) begin
            failures++;
            $display("FAIL b2b_done_low got=%0d exp=32", low);
        end
        checks++;
        if (result !== 32'h00000010 || {cout, ovf, zero} !== 3'b000) begin
            failures++;
            $display("FAIL b2b_result got=%h c/o/z=%b exp=00000010 000",
                     result, {cout, ovf, zero});
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || result !== 32'h00000010) begin
            failures++;
            $display("FAIL b2b_hold got done=%b res=%h exp 1 00000010", done, result);
        end
    endtask

    task automatic test_async_reset();
        int lat, bc;
        issue(32'h0000FFFF, 32'd1, 1'b0);
        repeat (15) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ready, busy, done, cout, ovf, zero} !== 6'b100000 || result !== 32'h0) begin
            failures++;
            $display("FAIL async_reset got r=%b b=%b d=%b c=%b o=%b z=%b res=%h exp 100000/0",
                     ready, busy, done, cout, ovf, zero, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        issue(32'd1, 32'd1, 1'b0);
        wait_done(0, lat, bc);
        checks++;
        if (lat !== 32 || result !== 32'h00000002) begin
            failures++;
            $display("FAIL post_reset got lat=%0d res=%h exp 32 00000002", lat, result);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_overflow();
        test_zero();
        test_step4();
        test_ignore_start();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
